mem_port_arbiter: RTL

//   Two-requester arbiter/sequencer for one single-port, synchronous-read word memory (DataMem-style:

---
 rtl/mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Two-requester arbiter/sequencer in front of one single-port, synchronous-
//   read word memory (address/data/strobes sampled at posedge Clk, read data
//   registered by the memory at that same edge). Port 0 is instruction fetch,
//   port 1 is load/store. Accesses are serialised through a three-state
//   sequence IDLE -> ACCESS -> RESP, one cycle each, so at most one access
//   completes every three cycles. Each completion is signalled by a one-cycle
//   ack pulse on the owning port.
//
//   Configuration macro:
//     ARB_ROUND_ROBIN_EN  defined   : round-robin between the ports. A 1-bit
//                                     pointer names the preferred port and is
//                                     set to the other port on every RESP.
//                         undefined : fixed priority, port1 beats port0.
//
//   Ports:
//     Clk, Rst_n                 clock, asynchronous active-low reset
//     req0/we0/addr0/wdata0      port0 request, write enable, byte address, data
//     ack0/rdata0                port0 completion pulse and read data
//     req1/we1/addr1/wdata1      port1 request (same meaning as port0)
//     ack1/rdata1                port1 completion pulse and read data
//     mem_addr/mem_wdata         to memory Address / writeData (unmodified)
//     mem_read/mem_write         to memory MemRead / MemWrite
//     mem_rdata                  from memory ReadData
//     busy                       high while in ACCESS or RESP
//     grant_id                   port owning the current / last transaction
//
//   The companion module mem_port_arbiter_chk holds protocol assertions.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          cmd_we_r;
    logic          grant_id_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          mem_read_r;
    logic          mem_write_r;
    logic          busy_r;
    logic          ack0_r;
    logic          ack1_r;
    logic [DW-1:0] rdata0_r;
    logic [DW-1:0] rdata1_r;
    logic [DW-1:0] rdata0_s;
    logic [DW-1:0] rdata1_s;

    logic          any_req_s;
    logic          win_id_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;

    assign any_req_s = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    // Port preferred on the next contended grant; 0 after reset so port0 goes first.
    logic rr_ptr_r;

    // Round-robin winner: pointer decides only when both ports request.
    always_comb begin
        win_id_s = 1'b0;
        if (req0 && req1) begin
            win_id_s = rr_ptr_r;
        end else if (req1) begin
            win_id_s = 1'b1;
        end else begin
            win_id_s = 1'b0;
        end
    end

    // Pointer moves to the port that did not own the transaction just completed.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (state_r == ST_RESP) begin
            rr_ptr_r <= ~grant_id_r;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed-priority winner: port1 always beats port0.
    always_comb begin
        win_id_s = 1'b0;
        if (req1) begin
            win_id_s = 1'b1;
        end else begin
            win_id_s = 1'b0;
        end
    end
`endif

    // Command fields of the winning port.
    always_comb begin
        win_we_s    = we0;
        win_addr_s  = addr0;
        win_wdata_s = wdata0;
        if (win_id_s) begin
            win_we_s    = we1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end else begin
            win_we_s    = we0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end
    end

    // Next-state logic for the IDLE -> ACCESS -> RESP sequence.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch and memory-side strobes: the command is captured at the
    // grant edge so the memory sees it for the whole ACCESS cycle and samples
    // it at the edge closing ACCESS. Address/data are held afterwards.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cmd_we_r    <= 1'b0;
            grant_id_r  <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        cmd_we_r    <= win_we_s;
                        grant_id_r  <= win_id_s;
                        mem_addr_r  <= win_addr_s;
                        mem_wdata_r <= win_wdata_s;
                        mem_read_r  <= ~win_we_s;
                        mem_write_r <= win_we_s;
                    end else begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                    end
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    // Requester-side handshake: busy spans ACCESS and RESP, the ack of the
    // owning port is high exactly for the RESP cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_r <= 1'b0;
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_ACCESS) || (state_nxt_s == ST_RESP);
            ack0_r <= (state_r == ST_ACCESS) && !grant_id_r;
            ack1_r <= (state_r == ST_ACCESS) &&  grant_id_r;
        end
    end

    // Read-data hold registers: after the ack cycle of a read, the owning
    // port keeps the word it was handed; writes leave it untouched.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdata0_r <= {DW{1'b0}};
            rdata1_r <= {DW{1'b0}};
        end else if ((state_r == ST_RESP) && !cmd_we_r) begin
            if (grant_id_r) begin
                rdata1_r <= mem_rdata;
            end else begin
                rdata0_r <= mem_rdata;
            end
        end else begin
            rdata0_r <= rdata0_r;
            rdata1_r <= rdata1_r;
        end
    end

    // The memory registers ReadData at the edge closing ACCESS, so the word
    // only exists during RESP; forward it straight to the owning port there.
    always_comb begin
        rdata0_s = rdata0_r;
        rdata1_s = rdata1_r;
        if ((state_r == ST_RESP) && !cmd_we_r) begin
            if (grant_id_r) begin
                rdata1_s = mem_rdata;
            end else begin
                rdata0_s = mem_rdata;
            end
        end else begin
            rdata0_s = rdata0_r;
            rdata1_s = rdata1_r;
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata0    = rdata0_s;
    assign rdata1    = rdata1_s;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;

endmodule

// ----------------------------------------------------------------------------
// mem_port_arbiter_chk
//   Protocol assertions for mem_port_arbiter; attach to the same signals.
//   Ports: Clk, Rst_n, ack0, ack1, busy, mem_read, mem_write (all inputs).
// ----------------------------------------------------------------------------
module mem_port_arbiter_chk (
    input logic Clk,
    input logic Rst_n,
    input logic ack0,
    input logic ack1,
    input logic busy,
    input logic mem_read,
    input logic mem_write
);

    a_ack_exclusive: assert property (@(posedge Clk) disable iff (!Rst_n)
        !(ack0 && ack1));

    a_strobe_exclusive: assert property (@(posedge Clk) disable iff (!Rst_n)
        !(mem_read && mem_write));

    a_ack_while_busy: assert property (@(posedge Clk) disable iff (!Rst_n)
        (ack0 || ack1) |-> busy);

    a_strobe_while_busy: assert property (@(posedge Clk) disable iff (!Rst_n)
        (mem_read || mem_write) |-> busy);

endmodule
